// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared helpers and encodings for the band-energy meter.
//   clog2       : ceiling log2 for elaborating counter and accumulator widths
//   mag_width   : width of an L1 bin magnitude for a given sample width
//   sum_width   : width of a band sum that can never overflow
//   state_t     : frame-walk FSM encoding (IDLE, ACCUM, UPDATE)
package spectrum_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // |re| + |im| reaches 2^DATA_W, which needs one bit more than a sample.
  function automatic int mag_width(input int data_w);
    return data_w + 1;
  endfunction

  // BPB magnitudes summed need clog2(BPB) extra bits of headroom.
  function automatic int sum_width(input int data_w, input int bpb);
    return mag_width(data_w) + clog2(bpb);
  endfunction

  // Widths for the default 8-bit, 8-bins-per-band configuration.
  localparam int DEF_MAG_W = mag_width(8);
  localparam int DEF_SUM_W = sum_width(8, 8);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

endpackage

// File: rtl/spectrum_mag_l1.sv
// spectrum_mag_l1: combinational L1 magnitude |re| + |im| of one complex bin.
//   re, im : signed two's-complement samples, DATA_W bits
//   mag    : unsigned magnitude, DATA_W+1 bits; the most negative sample
//            contributes exactly 2^(DATA_W-1), with no wrap
module spectrum_mag_l1
  import spectrum_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]              re,
  input  logic [DATA_W-1:0]              im,
  output logic [mag_width(DATA_W)-1:0]   mag
);

  localparam int MAG_BITS = mag_width(DATA_W);

  // Sign-extend one bit before negating so -2^(DATA_W-1) stays representable.
  function automatic logic [MAG_BITS-1:0] abs_ext(input logic [DATA_W-1:0] x);
    logic [MAG_BITS-1:0] ext;
    ext = {x[DATA_W-1], x};
    if (x[DATA_W-1]) begin
      return (~ext) + {{(MAG_BITS-1){1'b0}}, 1'b1};
    end else begin
      return ext;
    end
  endfunction

  // Sum of the two absolute values; bounded by 2^DATA_W so it fits MAG_BITS.
  always_comb begin
    mag = abs_ext(re) + abs_ext(im);
  end

endmodule

// File: rtl/spectrum_band_meter.sv
// spectrum_band_meter: band-energy meter with peak hold, fed by the FFT core.
// On fft_done in IDLE the frame is snapshotted and walked one bin per clock;
// per-band L1 sums are scaled, saturated and published on one UPDATE cycle.
//   clk, rst_n   : clock, asynchronous active-low reset
//   fft_real/imag: packed signed bins, bin k at [k*DATA_W +: DATA_W]
//   fft_done     : single-cycle frame-ready strobe
//   led_thresh   : LED on-threshold, sampled at the UPDATE edge
//   ovr_clr      : clears overrun (a simultaneous new overrun wins)
//   level_flat   : band levels, band b at [b*LEVEL_W +: LEVEL_W]
//   peak_flat    : peak-hold values, same packing
//   led_out      : per-band LEDs, active-low
//   frame_valid  : one-cycle pulse when outputs have updated
//   busy         : a frame is being processed
//   overrun      : sticky, a frame arrived while busy
module spectrum_band_meter
  import spectrum_pkg::*;
#(
  parameter int N_BINS      = 64,
  parameter int N_BANDS     = 8,
  parameter int DATA_W      = 8,
  parameter int LEVEL_W     = 8,
  parameter int SCALE_SHIFT = 2,
  parameter int HOLD_FRAMES = 4,
  parameter int DECAY_STEP  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_BINS*DATA_W-1:0]     fft_real,
  input  logic [N_BINS*DATA_W-1:0]     fft_imag,
  input  logic                         fft_done,
  input  logic [LEVEL_W-1:0]           led_thresh,
  input  logic                         ovr_clr,
  output logic [N_BANDS*LEVEL_W-1:0]   level_flat,
  output logic [N_BANDS*LEVEL_W-1:0]   peak_flat,
  output logic [N_BANDS-1:0]           led_out,
  output logic                         frame_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int BPB      = N_BINS / N_BANDS;
  localparam int MAG_BITS = mag_width(DATA_W);
  localparam int SUM_BITS = sum_width(DATA_W, BPB);
  localparam int IDX_W    = (clog2(N_BINS) > 0) ? clog2(N_BINS) : 1;
  localparam int POS_W    = (clog2(BPB) > 0) ? clog2(BPB) : 1;
  localparam int BAND_W   = (clog2(N_BANDS) > 0) ? clog2(N_BANDS) : 1;
  localparam int HOLD_W   = (clog2(HOLD_FRAMES + 1) > 0) ? clog2(HOLD_FRAMES + 1) : 1;

  state_t                state_r, next_state_s;
  logic [N_BINS*DATA_W-1:0] snap_re_r, snap_im_r;
  logic [IDX_W-1:0]      bin_idx_r;
  logic [POS_W-1:0]      pos_r;
  logic [BAND_W-1:0]     band_r;
  logic [SUM_BITS-1:0]   acc_r, acc_next_s;
  logic [DATA_W-1:0]     cur_re_s, cur_im_s;
  logic [MAG_BITS-1:0]   cur_mag_s;
  logic                  accept_s, last_bin_s, band_end_s;
  logic [LEVEL_W-1:0]    pending_r   [N_BANDS];
  logic [LEVEL_W-1:0]    level_r     [N_BANDS];
  logic [LEVEL_W-1:0]    peak_r      [N_BANDS];
  logic [LEVEL_W-1:0]    peak_next_s [N_BANDS];
  logic [HOLD_W-1:0]     hold_r      [N_BANDS];
  logic [HOLD_W-1:0]     hold_next_s [N_BANDS];

  // Shift then clamp to the largest displayable level.
  function automatic logic [LEVEL_W-1:0] sat_level(input logic [SUM_BITS-1:0] sum);
    logic [SUM_BITS-1:0]         shifted;
    logic [SUM_BITS+LEVEL_W-1:0] wide;
    shifted = sum >> SCALE_SHIFT;
    wide    = {{LEVEL_W{1'b0}}, shifted};
    if (wide > {{SUM_BITS{1'b0}}, {LEVEL_W{1'b1}}}) begin
      return {LEVEL_W{1'b1}};
    end else begin
      return wide[LEVEL_W-1:0];
    end
  endfunction

  spectrum_mag_l1 #(.DATA_W(DATA_W)) u_mag (
    .re  (cur_re_s),
    .im  (cur_im_s),
    .mag (cur_mag_s)
  );

  // Current bin selection and walk control decodes.
  always_comb begin
    cur_re_s   = snap_re_r[bin_idx_r*DATA_W +: DATA_W];
    cur_im_s   = snap_im_r[bin_idx_r*DATA_W +: DATA_W];
    acc_next_s = acc_r + {{(SUM_BITS-MAG_BITS){1'b0}}, cur_mag_s};
    accept_s   = (state_r == ST_IDLE) && fft_done;
    last_bin_s = (bin_idx_r == IDX_W'(N_BINS - 1));
    band_end_s = (pos_r == POS_W'(BPB - 1));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fft_done) begin
          next_state_s = ST_ACCUM;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (last_bin_s) begin
          next_state_s = ST_UPDATE;
        end else begin
          next_state_s = ST_ACCUM;
        end
      end
      ST_UPDATE: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Snapshot capture, bin walk counters, accumulator and pending levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_re_r <= {(N_BINS*DATA_W){1'b0}};
      snap_im_r <= {(N_BINS*DATA_W){1'b0}};
      bin_idx_r <= {IDX_W{1'b0}};
      pos_r     <= {POS_W{1'b0}};
      band_r    <= {BAND_W{1'b0}};
      acc_r     <= {SUM_BITS{1'b0}};
      for (int b = 0; b < N_BANDS; b++) begin
        pending_r[b] <= {LEVEL_W{1'b0}};
      end
    end else if (accept_s) begin
      snap_re_r <= fft_real;
      snap_im_r <= fft_imag;
      bin_idx_r <= {IDX_W{1'b0}};
      pos_r     <= {POS_W{1'b0}};
      band_r    <= {BAND_W{1'b0}};
      acc_r     <= {SUM_BITS{1'b0}};
    end else if (state_r == ST_ACCUM) begin
      bin_idx_r <= bin_idx_r + IDX_W'(1);
      if (band_end_s) begin
        // Band complete: this bin's magnitude is folded in before saturating.
        pending_r[band_r] <= sat_level(acc_next_s);
        acc_r             <= {SUM_BITS{1'b0}};
        pos_r             <= {POS_W{1'b0}};
        band_r            <= band_r + BAND_W'(1);
      end else begin
        acc_r <= acc_next_s;
        pos_r <= pos_r + POS_W'(1);
      end
    end
  end

  // Peak-hold / decay decision for every band, applied at UPDATE.
  always_comb begin
    for (int b = 0; b < N_BANDS; b++) begin
      peak_next_s[b] = peak_r[b];
      hold_next_s[b] = hold_r[b];
      if (pending_r[b] >= peak_r[b]) begin
        peak_next_s[b] = pending_r[b];
        hold_next_s[b] = HOLD_W'(HOLD_FRAMES);
      end else if (hold_r[b] != {HOLD_W{1'b0}}) begin
        hold_next_s[b] = hold_r[b] - HOLD_W'(1);
      end else if (peak_r[b] >= LEVEL_W'(DECAY_STEP)) begin
        peak_next_s[b] = peak_r[b] - LEVEL_W'(DECAY_STEP);
      end else begin
        peak_next_s[b] = {LEVEL_W{1'b0}};
      end
    end
  end

  // Published levels, peaks, LEDs and the frame_valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < N_BANDS; b++) begin
        level_r[b] <= {LEVEL_W{1'b0}};
        peak_r[b]  <= {LEVEL_W{1'b0}};
        hold_r[b]  <= {HOLD_W{1'b0}};
      end
      led_out     <= {N_BANDS{1'b1}};
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= (state_r == ST_UPDATE);
      if (state_r == ST_UPDATE) begin
        for (int b = 0; b < N_BANDS; b++) begin
          level_r[b] <= pending_r[b];
          peak_r[b]  <= peak_next_s[b];
          hold_r[b]  <= hold_next_s[b];
          led_out[b] <= ~(pending_r[b] > led_thresh);
        end
      end
    end
  end

  // Busy follows the next state so it rises on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (next_state_s != ST_IDLE);
    end
  end

  // Sticky overrun; a new overrun takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (fft_done && (state_r != ST_IDLE)) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

  // Flatten the per-band registers onto the output buses.
  always_comb begin
    level_flat = {(N_BANDS*LEVEL_W){1'b0}};
    peak_flat  = {(N_BANDS*LEVEL_W){1'b0}};
    for (int b = 0; b < N_BANDS; b++) begin
      level_flat[b*LEVEL_W +: LEVEL_W] = level_r[b];
      peak_flat[b*LEVEL_W +: LEVEL_W]  = peak_r[b];
    end
  end

endmodule

// File: tb/tb_spectrum_band_meter.sv
// Scoreboard bench for spectrum_band_meter (default parameters).
module tb_spectrum_band_meter;

  localparam int NBINS = 64;
  localparam int NB    = 8;
  localparam int DW    = 8;
  localparam int LW    = 8;
  localparam int BPB   = NBINS / NB;

  logic                 clk;
  logic                 rst_n;
  logic [NBINS*DW-1:0]  fft_real;
  logic [NBINS*DW-1:0]  fft_imag;
  logic                 fft_done;
  logic [LW-1:0]        led_thresh;
  logic                 ovr_clr;
  logic [NB*LW-1:0]     level_flat;
  logic [NB*LW-1:0]     peak_flat;
  logic [NB-1:0]        led_out;
  logic                 frame_valid;
  logic                 busy;
  logic                 overrun;

  spectrum_band_meter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fft_real    (fft_real),
    .fft_imag    (fft_imag),
    .fft_done    (fft_done),
    .led_thresh  (led_thresh),
    .ovr_clr     (ovr_clr),
    .level_flat  (level_flat),
    .peak_flat   (peak_flat),
    .led_out     (led_out),
    .frame_valid (frame_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  typedef struct {
    logic [NB*LW-1:0] lvl;
    logic [NB*LW-1:0] pk;
    logic [NB-1:0]    led;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   mpeak[NB];
  int   mhold[NB];
  logic [NB*LW-1:0] last_lvl;
  logic [NB*LW-1:0] last_pk;
  logic [NB-1:0]    last_led;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Random frame with samples in [-amp, amp]; amp >= 128 gives any byte.
  function automatic logic [NBINS*DW-1:0] rand_vec(input int amp);
    logic [NBINS*DW-1:0] v;
    int s;
    for (int k = 0; k < NBINS; k++) begin
      if (amp >= 128) s = int'($urandom_range(0, 255));
      else s = int'($urandom_range(0, 2 * amp)) - amp;
      v[k*DW +: DW] = 8'(s);
    end
    return v;
  endfunction

  function automatic logic [NBINS*DW-1:0] fill_vec(input int first, input int last, input int val);
    logic [NBINS*DW-1:0] v;
    v = '0;
    for (int k = first; k <= last; k++) v[k*DW +: DW] = 8'(val);
    return v;
  endfunction

  // Reference: band energies, display levels, peak hold and LEDs from the rules.
  task automatic model_frame(input logic [NBINS*DW-1:0] re, input logic [NBINS*DW-1:0] im,
                             input int thr, output exp_t e);
    for (int b = 0; b < NB; b++) begin
      int sum;
      int lvl;
      sum = 0;
      for (int j = 0; j < BPB; j++) begin
        int k;
        k = b * BPB + j;
        sum += iabs(int'($signed(re[k*DW +: DW]))) + iabs(int'($signed(im[k*DW +: DW])));
      end
      lvl = sum / 4;
      if (lvl > 255) lvl = 255;
      if (lvl >= mpeak[b]) begin
        mpeak[b] = lvl;
        mhold[b] = 4;
      end else if (mhold[b] > 0) begin
        mhold[b] = mhold[b] - 1;
      end else begin
        mpeak[b] = (mpeak[b] - 8 < 0) ? 0 : mpeak[b] - 8;
      end
      e.lvl[b*LW +: LW] = 8'(lvl);
      e.pk[b*LW +: LW]  = 8'(mpeak[b]);
      e.led[b]          = (lvl > thr) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Caller is at a negedge; issues fft_done and pushes the expected result.
  task automatic start_frame(input logic [NBINS*DW-1:0] re, input logic [NBINS*DW-1:0] im,
                             input int thr);
    exp_t e;
    model_frame(re, im, thr, e);
    e.cyc = cyc + 66;
    q.push_back(e);
    led_thresh = 8'(thr);
    fft_real   = re;
    fft_imag   = im;
    fft_done   = 1'b1;
    @(posedge clk);
    #1;
    fft_done = 1'b0;
    fft_real = rand_vec(128);
    fft_imag = rand_vec(128);
    check_bit("busy_after_accept", busy, 1'b1);
  endtask

  // Waits (bounded) for the scoreboard to drain, then realigns to a negedge.
  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL frame_timeout: %0d frames outstanding, expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      mpeak[b] = 0;
      mhold[b] = 0;
    end
  endtask

  // Monitor: pops and compares on frame_valid; otherwise outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_lvl = '0;
      last_pk  = '0;
      last_led = '1;
    end else if (frame_valid) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_frame_valid: pulse at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc) begin
          fails++;
          $display("FAIL latency: frame_valid at cycle %0d expected %0d", cyc, e.cyc);
        end
        checks += 4;
        if (level_flat !== e.lvl) begin
          fails++;
          $display("FAIL level_flat: got %h expected %h", level_flat, e.lvl);
        end
        if (peak_flat !== e.pk) begin
          fails++;
          $display("FAIL peak_flat: got %h expected %h", peak_flat, e.pk);
        end
        if (led_out !== e.led) begin
          fails++;
          $display("FAIL led_out: got %h expected %h", led_out, e.led);
        end
        if (busy !== 1'b0) begin
          fails++;
          $display("FAIL busy_at_valid: got %0b expected 0", busy);
        end
      end
      last_lvl = level_flat;
      last_pk  = peak_flat;
      last_led = led_out;
    end else begin
      checks++;
      if (level_flat !== last_lvl || peak_flat !== last_pk || led_out !== last_led) begin
        fails++;
        $display("FAIL outputs_stable: lvl %h pk %h led %h, expected lvl %h pk %h led %h",
                 level_flat, peak_flat, led_out, last_lvl, last_pk, last_led);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (level_flat !== '0 || peak_flat !== '0 || led_out !== 8'hFF ||
        frame_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL %s: lvl %h pk %h led %h fv %0b busy %0b ovr %0b, expected 0 0 ff 0 0 0",
               tag, level_flat, peak_flat, led_out, frame_valid, busy, overrun);
    end
  endtask

  initial begin
    int amps[4];
    amps = '{3, 15, 63, 128};
    rst_n      = 1'b0;
    fft_real   = '0;
    fft_imag   = '0;
    fft_done   = 1'b0;
    led_thresh = '0;
    ovr_clr    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    // 1. Saturation: every bin -128/-128.
    start_frame(fill_vec(0, 63, -128), fill_vec(0, 63, -128), 128);
    wait_done();

    // 2. Single band: bins 8..15 re=10 im=-6.
    start_frame(fill_vec(8, 15, 10), fill_vec(8, 15, -6), 31);
    wait_done();

    // 3. Peak hold then decay to a clamped zero.
    start_frame(fill_vec(0, 7, 60), fill_vec(0, 7, -40), 100);
    wait_done();
    for (int f = 0; f < 30; f++) begin
      start_frame('0, '0, 0);
      wait_done();
    end

    // 4. Overrun: a second fft_done at E10 is ignored and sets overrun.
    start_frame(rand_vec(63), rand_vec(63), 50);
    repeat (9) @(posedge clk);
    @(negedge clk);
    fft_done = 1'b1;
    @(posedge clk);
    #1;
    fft_done = 1'b0;
    check_bit("overrun_set", overrun, 1'b1);
    wait_done();
    check_bit("overrun_sticky", overrun, 1'b1);
    ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    ovr_clr = 1'b0;
    check_bit("overrun_cleared", overrun, 1'b0);
    @(negedge clk);
    start_frame(rand_vec(15), rand_vec(15), 10);
    repeat (5) @(posedge clk);
    @(negedge clk);
    fft_done = 1'b1;
    ovr_clr  = 1'b1;
    @(posedge clk);
    #1;
    fft_done = 1'b0;
    ovr_clr  = 1'b0;
    check_bit("overrun_set_wins", overrun, 1'b1);
    wait_done();
    ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    ovr_clr = 1'b0;
    check_bit("overrun_cleared2", overrun, 1'b0);
    @(negedge clk);

    // 5 + random: frames, some issued back-to-back in the frame_valid cycle.
    for (int f = 0; f < 12; f++) begin
      int amp;
      amp = amps[$urandom_range(0, 3)];
      start_frame(rand_vec(amp), rand_vec(amp), int'($urandom_range(0, 255)));
      if (f % 3 == 0) begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!frame_valid && n < 200);
        checks++;
        if (!frame_valid) begin
          fails++;
          $display("FAIL b2b_wait: frame_valid not seen within %0d cycles", n);
        end
        amp = amps[$urandom_range(0, 3)];
        start_frame(rand_vec(amp), rand_vec(amp), int'($urandom_range(0, 255)));
        check_bit("b2b_no_overrun", overrun, 1'b0);
      end
      wait_done();
    end

    // 6. Reset at E30 aborts the frame.
    start_frame(fill_vec(0, 63, -128), fill_vec(0, 63, 127), 0);
    wait_done();
    start_frame(rand_vec(128), rand_vec(128), 0);
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_midframe");
    q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check_reset_outputs("after_reset_idle");

    start_frame(rand_vec(63), rand_vec(63), 40);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/spectrum_band_meter.md
# spectrum_band_meter

Parametrised band-energy meter with peak hold. It sits after the FFT core in the audio spectrum analyser. On each `fft_done` it snapshots one frame of complex bins and walks them serially, one bin per clock. It sums an L1 magnitude per band, scales and saturates each sum to a display level, and updates per-band peak-hold/decay registers and active-low LED outputs. It replaces the fixed 8-band, single-bin-per-band display path.

## Interface
Parameters:
- `N_BINS`, 64: FFT bins per frame. Must be a multiple of `N_BANDS`.
- `N_BANDS`, 8: number of display bands.
- `DATA_W`, 8: width of each signed two's-complement real/imag bin.
- `LEVEL_W`, 8: width of each band level and peak.
- `SCALE_SHIFT`, 2: right shift applied to a band sum before saturation.
- `HOLD_FRAMES`, 4: frames a new peak is held before decay begins.
- `DECAY_STEP`, 8: amount subtracted from a peak per frame once its hold has expired.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `fft_real`, in, `N_BINS*DATA_W`: real parts. Bin k is `[k*DATA_W +: DATA_W]`.
- `fft_imag`, in, `N_BINS*DATA_W`: imaginary parts, same packing as `fft_real`.
- `fft_done`, in, 1: single-cycle frame-ready strobe.
- `led_thresh`, in, `LEVEL_W`: LED on-threshold.
- `ovr_clr`, in, 1: clears `overrun`.
- `level_flat`, out, `N_BANDS*LEVEL_W`: current band levels. Band b is `[b*LEVEL_W +: LEVEL_W]`.
- `peak_flat`, out, `N_BANDS*LEVEL_W`: peak-hold values, same packing as `level_flat`.
- `led_out`, out, `N_BANDS`: per-band LED, active-low.
- `frame_valid`, out, 1: one-cycle pulse when all outputs have updated.
- `busy`, out, 1: high while a frame is being processed.
- `overrun`, out, 1: sticky flag; a frame arrived while the block was busy.

## Operation
- Derived constant: BPB = `N_BINS/N_BANDS`.
- Magnitude of bin k = |re| + |im|, `DATA_W+1` bits unsigned.
  - |−2^(DATA_W−1)| = 2^(DATA_W−1), held exactly with no wrap.
- Band sum width is `DATA_W+1+clog2(BPB)`, so the sum never overflows.
- Band level = min(sum >> `SCALE_SHIFT`, 2^`LEVEL_W`−1).
- States:
  - IDLE:
    - `fft_done`=1 → snapshot `fft_real`/`fft_imag` into internal registers, clear bin index k and the accumulator, go to ACCUM.
  - ACCUM, one bin per clock:
    - Add mag(k) into the accumulator.
    - When k mod BPB = BPB−1: write the scaled, saturated level into `pending[k/BPB]` and clear the accumulator.
    - When k = `N_BINS`−1 → go to UPDATE.
  - UPDATE, one cycle, all bands in parallel:
    - `level_flat` ← pending.
    - Peak update per band:
      - If level ≥ peak: peak ← level, hold ← `HOLD_FRAMES`.
      - Else if hold > 0: hold ← hold−1.
      - Else: peak ← max(peak−`DECAY_STEP`, 0).
    - `led_out[b]` ← ~(level[b] > `led_thresh`).
    - Pulse `frame_valid`, go to IDLE.
- `busy` = (state ≠ IDLE).
- Overrun handling:
  - `fft_done` while `busy` is ignored, the snapshot is not disturbed, and `overrun` is set.
  - `overrun` is cleared by `ovr_clr`.
  - Simultaneous set and clear → set wins.
- Input bins are used only from the snapshot, so the FFT may overwrite its outputs one cycle after `fft_done`.

## Timing
- Reset values:
  - Outputs: `level_flat`=0, `peak_flat`=0, `led_out`=all ones (LEDs off), `frame_valid`=0, `busy`=0, `overrun`=0.
  - Internal: hold counters 0, state IDLE.
- Edge E0 samples `fft_done`=1 in IDLE. `busy` is high from E0.
- Edges E1..E`N_BINS` each accumulate one bin.
- Edge E`N_BINS`+1, the UPDATE edge:
  - Updates all outputs.
  - Asserts `frame_valid` for exactly one cycle.
  - Drops `busy`.
- Latency from the `fft_done` sample to `frame_valid` is `N_BINS`+1 clocks; with defaults, 65.
- `fft_done` coincident with `frame_valid` is accepted (state is IDLE), so there is no dead cycle.
- Outputs are stable between `frame_valid` pulses.
- `rst_n` asserted mid-frame aborts immediately: all registers return to reset values and no `frame_valid` is produced.
- `led_thresh` is sampled only at the UPDATE edge.

## Structure
- Package `spectrum_pkg`:
  - `clog2` function.
  - Derived width constants: magnitude width and band sum width.
  - State encoding: IDLE, ACCUM, UPDATE.
- Sub-module `spectrum_mag_l1`: combinational |re|+|im| for one bin, parameter `DATA_W`.
- The top level holds the FSM, snapshot registers, accumulator, pending array, and peak/hold arrays.

## Test plan
All scenarios use default parameters.
1. Saturation: all bins re=−128, im=−128 → each band sum 8×256=2048, >>2 = 512 → every level 255. With `led_thresh`=128, `led_out`=8'h00. `frame_valid` arrives 65 cycles after `fft_done`.
2. Single band: bins 8..15 re=10, im=−6, all others 0 → band 1 level = 8×16>>2 = 32; all other levels 0. With `led_thresh`=31, `led_out`=8'hFD.
3. Peak hold and decay: frame with band 0 level 200, then zero frames →
   - `peak[0]` stays 200 for frames 2–5.
   - Frame 6 gives 192, then decrements by 8 per frame.
   - Clamps at 0, with no wrap.
4. Overrun: second `fft_done` at E10 →
   - Ignored; the first frame's results are unchanged.
   - `overrun`=1 until `ovr_clr`.
   - `ovr_clr` coincident with a new overrun leaves `overrun`=1.
5. Back-to-back: `fft_done` in the `frame_valid` cycle is accepted, `overrun` stays 0, and the next `frame_valid` follows 65 cycles later.
6. Reset at E30 of a frame → all outputs return to reset values, `busy`=0, and no `frame_valid` follows.
